// File: rtl/fetch_controller.sv
// ---------------------------------------------------------------------------
// fetch_controller
//
// Instruction fetch sequencer for the pipelined SimpleRISC core. Owns the
// fetch PC, drives a synchronous-read instruction memory (1-cycle read
// latency, read data held while enable is low) and presents each returned
// word to decode together with its address and a valid flag.
//
// Handles:
//   - start-up from IDLE on a start pulse
//   - stall back-pressure: the memory is not re-read, so the held read data
//     keeps the presented instruction stable
//   - branch redirect: the instruction already on the outputs is still
//     presented, then one bubble (FLUSH) while the target is read
//   - optional halt detection (opcode 5'b11111 accepted by decode)
//
// Optional feature macro: FETCH_HALT_DETECT_EN
//   defined   : HALT state exists, halted reports it
//   undefined : no HALT state, halted tied low, opcode 11111 is ordinary
//
// Parameters:
//   N        instruction-memory word address width
//   RESET_PC first fetch address after reset
//
// Ports:
//   clka          clock, all state on rising edge
//   rst           asynchronous active-high reset
//   start         leave IDLE and begin fetching (ignored elsewhere)
//   stall         decode cannot accept; hold the current instruction
//   branch_taken  redirect request from execute
//   branch_target redirect address
//   im_ena        memory read enable
//   im_addra      memory read address (the fetch PC)
//   im_douta      memory read data
//   inst_out      instruction to decode (0 when nothing issued)
//   pc_out        address of inst_out
//   inst_valid    inst_out/pc_out carry a real instruction
//   fetch_count   instructions accepted by decode, saturating
//   halted        fetch stopped by a halt instruction
// ---------------------------------------------------------------------------
module fetch_controller #(
    parameter int           N        = 7,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clka,
    input  logic         rst,
    input  logic         start,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    output logic         im_ena,
    output logic [N-1:0] im_addra,
    input  logic [31:0]  im_douta,
    output logic [31:0]  inst_out,
    output logic [N-1:0] pc_out,
    output logic         inst_valid,
    output logic [15:0]  fetch_count,
    output logic         halted
);

`ifdef FETCH_HALT_DETECT_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;
`endif

    state_t       state;
    logic [N-1:0] fetch_pc;      // address of the next memory read
    logic [N-1:0] issued_pc;     // address whose data sits on im_douta
    logic         issued_valid;  // im_douta holds a live instruction
    logic         accept;

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    assign im_addra = fetch_pc;
    assign pc_out   = issued_pc;
    assign inst_out = issued_valid ? im_douta : 32'd0;

`ifdef FETCH_HALT_DETECT_EN
    assign inst_valid = issued_valid && (state != S_FLUSH) && (state != S_HALT);
`else
    assign inst_valid = issued_valid && (state != S_FLUSH);
`endif

    assign accept = inst_valid && !stall;

    // A read is issued only when its data will be consumed: in RUN when
    // neither stalled nor redirected, in FLUSH unless a newer branch
    // overrides the target. Keeping enable low otherwise is what lets the
    // memory hold the presented word through a stall.
    always_comb begin
        im_ena = 1'b0;
        case (state)
            S_RUN:   im_ena = !stall && !branch_taken;
            S_FLUSH: im_ena = !branch_taken;
            default: im_ena = 1'b0;
        endcase
    end

`ifdef FETCH_HALT_DETECT_EN
    logic halt_hit;
    // inst_out equals im_douta whenever accept is high
    assign halt_hit = accept && (im_douta[31:27] == 5'b11111);
`endif

    // ------------------------------------------------------------------
    // Fetch state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            fetch_pc     <= RESET_PC;
            issued_pc    <= '0;
            issued_valid <= 1'b0;
`ifdef FETCH_HALT_DETECT_EN
            halted       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start)
                        state <= S_RUN;
                end

                S_RUN: begin
`ifdef FETCH_HALT_DETECT_EN
                    // Halt beats a same-cycle branch.
                    if (halt_hit) begin
                        state        <= S_HALT;
                        issued_valid <= 1'b0;
                        halted       <= 1'b1;
                    end else
`endif
                    if (branch_taken) begin
                        // The word on the outputs this cycle is still
                        // offered to decode; nothing behind it survives.
                        fetch_pc     <= branch_target;
                        issued_valid <= 1'b0;
                        state        <= S_FLUSH;
                    end else if (!stall) begin
                        issued_pc    <= fetch_pc;
                        issued_valid <= 1'b1;
                        fetch_pc     <= fetch_pc + 1'b1;  // wraps at 2^N-1
                    end
                end

                S_FLUSH: begin
                    if (branch_taken) begin
                        // Newer redirect replaces the pending target.
                        fetch_pc <= branch_target;
                    end else begin
                        issued_pc    <= fetch_pc;
                        issued_valid <= 1'b1;
                        fetch_pc     <= fetch_pc + 1'b1;
                        state        <= S_RUN;
                    end
                end

`ifdef FETCH_HALT_DETECT_EN
                S_HALT: begin
                    // Terminal until reset.
                end
`endif

                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef FETCH_HALT_DETECT_EN
    assign halted = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Accepted-instruction counter, saturating
    // ------------------------------------------------------------------
    always_ff @(posedge clka or posedge rst) begin
        if (rst)
            fetch_count <= '0;
        else if (accept && (fetch_count != 16'hFFFF))
            fetch_count <= fetch_count + 16'd1;
    end

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

    localparam int N     = 7;
    localparam int DEPTH = 1 << N;

    logic         clka = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         stall = 1'b0;
    logic         branch_taken = 1'b0;
    logic [N-1:0] branch_target = '0;
    logic         im_ena;
    logic [N-1:0] im_addra;
    logic [31:0]  im_douta = 32'd0;
    logic [31:0]  inst_out;
    logic [N-1:0] pc_out;
    logic         inst_valid;
    logic [15:0]  fetch_count;
    logic         halted;

    fetch_controller #(.N(N), .RESET_PC('0)) dut (
        .clka(clka), .rst(rst), .start(start), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .im_ena(im_ena), .im_addra(im_addra), .im_douta(im_douta),
        .inst_out(inst_out), .pc_out(pc_out), .inst_valid(inst_valid),
        .fetch_count(fetch_count), .halted(halted)
    );

    always #5 clka = ~clka;

    // Synchronous-read memory: 1-cycle latency, holds data while disabled.
    logic [31:0] mem [DEPTH];
    always @(posedge clka) if (im_ena) im_douta <= mem[im_addra];

`ifdef FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: which address is being presented, which is next,
    // and what phase the fetcher is in (0 idle, 1 streaming, 2 bubble, 3 halted).
    int m_mode;
    bit m_has;    // an instruction is presented
    int m_pc;     // its address
    int m_next;   // next address to read
    int m_count;

    task automatic model_reset();
        m_mode = 0; m_has = 0; m_pc = 0; m_next = 0; m_count = 0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst",  inst_out, 0);
        chk("rst_pc",    pc_out, 0);
        chk("rst_ena",   im_ena, 0);
        chk("rst_count", fetch_count, 0);
        chk("rst_halted", halted, 0);
    endtask

    // Assert reset asynchronously in mid-cycle; outputs must clear at once.
    task automatic async_reset();
        @(negedge clka);
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        model_reset();
        @(posedge clka);
    endtask

    // One clock: drive inputs, check outputs against the model, advance model.
    task automatic step(input bit s, input bit st, input bit br, input int tgt);
        bit ev, ee, acc;
        @(negedge clka);
        rst = 1'b0; start = s; stall = st; branch_taken = br;
        branch_target = tgt[N-1:0];
        #1;
        ev = (m_mode == 1) && m_has;
        chk("valid", inst_valid, ev);
        if (ev) begin
            chk("pc",   pc_out, m_pc);
            chk("inst", inst_out, mem[m_pc]);
        end else begin
            chk("inst_zero", inst_out, 0);
        end
        ee = ((m_mode == 1) && !st && !br) || ((m_mode == 2) && !br);
        chk("ena", im_ena, ee);
        if (ee) chk("addr", im_addra, m_next);
        chk("count",  fetch_count, m_count);
        chk("halted", halted, m_mode == 3);

        acc = ev && !st;
        if (acc && m_count < 65535) m_count++;
        case (m_mode)
            0: if (s) m_mode = 1;
            1: begin
                if (HALT_EN && acc && mem[m_pc][31:27] == 5'b11111) begin
                    m_mode = 3; m_has = 0;
                end else if (br) begin
                    m_next = tgt % DEPTH; m_has = 0; m_mode = 2;
                end else if (!st) begin
                    m_pc = m_next; m_has = 1; m_next = (m_next + 1) % DEPTH;
                end
            end
            2: begin
                if (br) m_next = tgt % DEPTH;
                else begin
                    m_pc = m_next; m_has = 1; m_next = (m_next + 1) % DEPTH; m_mode = 1;
                end
            end
            default: ;
        endcase
    endtask

    // Free-run until the given address is presented (bounded).
    task automatic run_to(input int pc);
        int n = 0;
        while (!(m_mode == 1 && m_has && m_pc == pc) && n < 400) begin
            step(0, 0, 0, 0);
            n++;
        end
        chk("reach_pc", (m_mode == 1 && m_has && m_pc == pc), 1);
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) mem[k] = k;
        model_reset();
        #1 check_reset_outputs();
        repeat (2) @(posedge clka);

        // Start-up: first valid exactly two cycles after start is sampled.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("first_latency_invalid", inst_valid, 0);
        step(0, 0, 0, 0);
        chk("first_latency_valid", inst_valid, 1);
        chk("first_pc", pc_out, 0);

        // Stall three cycles at pc 5.
        run_to(5);
        repeat (3) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("resume_pc", pc_out, 6);

        // Branch to 40 while presenting 10, with an accepted branch-cycle word.
        run_to(10);
        step(0, 0, 1, 40);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("branch_target_pc", pc_out, 40);
        step(0, 0, 0, 0);
        // Branch under stall, then a second branch during the bubble.
        step(0, 1, 1, 90);
        step(0, 1, 1, 100);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);

        // Branch to the top address wraps to 0.
        step(0, 0, 1, DEPTH - 1);
        repeat (5) step(0, 0, 0, 0);

        // start ignored while running; reset mid-stream.
        step(1, 0, 0, 0);
        run_to(20);
        async_reset();
        repeat (3) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0);

        // Halt opcode at word 3.
        async_reset();
        mem[3] = 32'hF800_0000;
        step(1, 0, 0, 0);
        repeat (6) step(0, 0, 0, 0);
        step(0, 0, 1, 50);
        repeat (3) step(1, 0, 0, 0);
        mem[3] = 3;

        // Randomized traffic with random memory contents.
        async_reset();
        for (int k = 0; k < DEPTH; k++) mem[k] = $urandom;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(0, 9) == 0, $urandom_range(0, 9) < 3,
                     $urandom_range(0, 9) == 0, $urandom_range(0, DEPTH - 1));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
